// File: rtl/apb_arbiter.sv
// apb_arbiter: two-requester round-robin arbiter in front of one APB completer.
// Each requester presents a level request plus addr/wdata/write; the arbiter
// runs one APB transfer (SETUP, ACCESS, DONE) for the winner and returns a
// one-cycle ready pulse with read data.
//
// Optional feature macro: APB_ARB_TIMEOUT_EN
//   When defined, an ACCESS phase that sees no PREADY for TIMEOUT_CYCLES cycles
//   is forced to DONE with rdata=0 and the owner's error flag set. When left
//   undefined, ACCESS waits for PREADY indefinitely and both error outputs are 0.
module apb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,

    input  logic        m0_transfer,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_write,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_error,

    input  logic        m1_transfer,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_write,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_error,

    output logic        grant,

    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e      state_q;
    logic        grant_q;
    logic        last_grant_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic        pwrite_q;
    logic        psel_q;
    logic        penable_q;
    logic        m0_ready_q;
    logic        m1_ready_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;

    // Winner of the current IDLE-cycle arbitration.
    logic        winner_d;
    // High in the ACCESS cycle where the timeout limit forces completion.
    logic        timeout_hit;

    // Round-robin pick: a lone requester always wins, a tie goes to the one
    // that did not own the bus last.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        winner_d = 1'b0;
        if (m0_transfer && m1_transfer) begin
            winner_d = ~last_grant_q;
        end else if (m1_transfer) begin
            winner_d = 1'b1;
        end
    end

    // Transfer sequencer with all APB and requester-side outputs registered.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            // Ready is a single-cycle pulse; it is only set on the way into DONE.
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m0_transfer || m1_transfer) begin
                        grant_q   <= winner_d;
                        paddr_q   <= winner_d ? m1_addr  : m0_addr;
                        pwdata_q  <= winner_d ? m1_wdata : m0_wdata;
                        pwrite_q  <= winner_d ? m1_write : m0_write;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over a timeout reached in the same cycle.
                    if (PREADY || timeout_hit) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= DONE;
                        if (grant_q) begin
                            m1_ready_q <= 1'b1;
                            m1_rdata_q <= (PREADY && !pwrite_q) ? PRDATA : '0;
                        end else begin
                            m0_ready_q <= 1'b1;
                            m0_rdata_q <= (PREADY && !pwrite_q) ? PRDATA : '0;
                        end
                    end
                end
                DONE: begin
                    // Requests are not sampled here, so the owner cannot be re-granted
                    // on the strength of a transfer it is about to drop.
                    last_grant_q <= grant_q;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned       CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             m0_error_q;
    logic             m1_error_q;

    assign timeout_hit = (state_q == ACCESS) && !PREADY && (cnt_q == CNT_LAST);

    // Count waited ACCESS cycles (cleared in SETUP so ACCESS starts at 0) and
    // raise the owner's error flag alongside the forced ready pulse.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q      <= '0;
            m0_error_q <= 1'b0;
            m1_error_q <= 1'b0;
        end else begin
            if (state_q == SETUP) begin
                cnt_q <= '0;
            end else if ((state_q == ACCESS) && !PREADY && (cnt_q != CNT_LAST)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            m0_error_q <= timeout_hit && !grant_q;
            m1_error_q <= timeout_hit &&  grant_q;
        end
    end

    assign m0_error = m0_error_q;
    assign m1_error = m1_error_q;
`else
    assign timeout_hit = 1'b0;
    assign m0_error    = 1'b0;
    assign m1_error    = 1'b0;
`endif

    assign grant    = grant_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign PWRITE   = pwrite_q;
    assign PSEL     = psel_q;
    assign PENABLE  = penable_q;
    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed testbench for apb_arbiter. Inputs change 1 ns after a rising edge
// and outputs are checked at that same point, away from the active edge.
// Honours APB_ARB_TIMEOUT_EN the same way the design does.
`timescale 1ns/1ps
module tb_apb_arbiter;

    logic        PCLK;
    logic        PRESET;
    logic        m0_transfer, m1_transfer;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_write, m1_write;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_error, m1_error;
    logic        grant;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;

    int checks = 0;
    int errors = 0;

    apb_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .m0_transfer (m0_transfer),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_write    (m0_write),
        .m0_ready    (m0_ready),
        .m0_rdata    (m0_rdata),
        .m0_error    (m0_error),
        .m1_transfer (m1_transfer),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_write    (m1_write),
        .m1_ready    (m1_ready),
        .m1_rdata    (m1_rdata),
        .m1_error    (m1_error),
        .grant       (grant),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Hard stop in case something goes badly wrong.
    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, expected normal end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int seen;

        PRESET      = 1'b0;
        m0_transfer = 1'b0; m1_transfer = 1'b0;
        m0_addr     = '0;   m1_addr     = '0;
        m0_wdata    = '0;   m1_wdata    = '0;
        m0_write    = 1'b0; m1_write    = 1'b0;
        PRDATA      = '0;   PREADY      = 1'b0;

        // ---- reset values, visible before any clock edge ----
        #1 PRESET = 1'b1;
        #2;
        check("rst_psel",     32'(PSEL),     32'd0);
        check("rst_penable",  32'(PENABLE),  32'd0);
        check("rst_m0_ready", 32'(m0_ready), 32'd0);
        check("rst_m1_ready", 32'(m1_ready), 32'd0);
        check("rst_m0_error", 32'(m0_error), 32'd0);
        check("rst_m1_error", 32'(m1_error), 32'd0);
        check("rst_grant",    32'(grant),    32'd0);
        check("rst_paddr",    PADDR,         32'h0);
        check("rst_m0_rdata", m0_rdata,      32'h0);
        step();
        PRESET = 1'b0;

        // ---- single read by m0, PREADY on first ACCESS cycle ----
        m0_addr = 32'h1000_0004; m0_write = 1'b0; m0_transfer = 1'b1;
        step();                                      // N+1: SETUP
        check("rd_setup_psel",    32'(PSEL),    32'd1);
        check("rd_setup_penable", 32'(PENABLE), 32'd0);
        check("rd_setup_grant",   32'(grant),   32'd0);
        check("rd_setup_paddr",   PADDR,        32'h1000_0004);
        check("rd_setup_pwrite",  32'(PWRITE),  32'd0);
        step();                                      // N+2: ACCESS
        check("rd_access_psel",    32'(PSEL),    32'd1);
        check("rd_access_penable", 32'(PENABLE), 32'd1);
        PREADY = 1'b1; PRDATA = 32'hA5A5_0001;
        step();                                      // N+3: DONE
        check("rd_m0_ready",   32'(m0_ready), 32'd1);
        check("rd_m0_rdata",   m0_rdata,      32'hA5A5_0001);
        check("rd_m1_ready",   32'(m1_ready), 32'd0);
        check("rd_done_psel",  32'(PSEL),     32'd0);
        PREADY = 1'b0; PRDATA = 32'h0;
        step();                                      // IDLE; m0 still high through DONE
        check("rd_no_regrant", 32'(PSEL),     32'd0);
        check("rd_ready_pulse",32'(m0_ready), 32'd0);
        check("rd_rdata_hold", m0_rdata,      32'hA5A5_0001);
        m0_transfer = 1'b0;

        // ---- m1 write with three wait states ----
        m1_addr = 32'h1000_2000; m1_wdata = 32'hDEAD_BEEF; m1_write = 1'b1; m1_transfer = 1'b1;
        step();                                      // SETUP
        check("wr_grant",  32'(grant),  32'd1);
        check("wr_pwrite", 32'(PWRITE), 32'd1);
        m1_addr = 32'hFFFF_0000; m1_wdata = 32'h0;   // must be ignored after latch
        for (int i = 1; i <= 4; i++) begin
            step();                                  // ACCESS cycle i
            check($sformatf("wr_paddr_%0d", i),   PADDR,        32'h1000_2000);
            check($sformatf("wr_pwdata_%0d", i),  PWDATA,       32'hDEAD_BEEF);
            check($sformatf("wr_penable_%0d", i), 32'(PENABLE), 32'd1);
            if (i == 4) PREADY = 1'b1;
        end
        PRDATA = 32'h1234_5678;                      // write must still return 0
        step();                                      // DONE
        check("wr_m1_ready", 32'(m1_ready), 32'd1);
        check("wr_m1_rdata", m1_rdata,      32'h0);
        check("wr_m0_ready", 32'(m0_ready), 32'd0);
        PREADY = 1'b0;
        step();
        check("wr_ready_pulse", 32'(m1_ready), 32'd0);
        m1_transfer = 1'b0; m1_write = 1'b0;

        // ---- reset, then contention: m0 first, then m1 ----
        PRESET = 1'b1;
        #1;
        check("rst2_m0_rdata", m0_rdata, 32'h0);
        check("rst2_paddr",    PADDR,    32'h0);
        check("rst2_pwrite",   32'(PWRITE), 32'd0);
        step();
        PRESET = 1'b0;
        m0_addr = 32'h100; m1_addr = 32'h200; m0_transfer = 1'b1; m1_transfer = 1'b1;
        step();
        check("tie1_grant", 32'(grant), 32'd0);
        check("tie1_paddr", PADDR,      32'h100);
        step();
        PREADY = 1'b1; PRDATA = 32'h1111_1111;
        step();
        check("tie1_m0_ready", 32'(m0_ready), 32'd1);
        check("tie1_m0_rdata", m0_rdata,      32'h1111_1111);
        step();                                      // IDLE; m0 drops, m1 still waiting
        m0_transfer = 1'b0; PRDATA = 32'h2222_2222;
        step();
        check("tie1_second_grant", 32'(grant), 32'd1);
        check("tie1_second_paddr", PADDR,      32'h200);
        step();
        step();
        check("tie1_m1_ready",  32'(m1_ready), 32'd1);
        check("tie1_m1_rdata",  m1_rdata,      32'h2222_2222);
        check("tie1_m0_quiet",  32'(m0_ready), 32'd0);
        check("tie1_m0_hold",   m0_rdata,      32'h1111_1111);
        step();
        m1_transfer = 1'b0;

        // ---- m0 alone, then both again: m1 must win the tie ----
        m0_addr = 32'h300; m0_transfer = 1'b1; PRDATA = 32'h3333_3333;
        step();
        check("solo_grant", 32'(grant), 32'd0);
        step();
        step();
        check("solo_m0_ready", 32'(m0_ready), 32'd1);
        step();
        m0_transfer = 1'b0;
        step();                                      // one quiet IDLE cycle
        m0_transfer = 1'b1; m1_addr = 32'h400; m1_transfer = 1'b1; PRDATA = 32'h4444_4444;
        step();
        check("tie2_grant", 32'(grant), 32'd1);
        check("tie2_paddr", PADDR,      32'h400);
        step();
        step();
        check("tie2_m1_ready", 32'(m1_ready), 32'd1);
        check("tie2_m1_rdata", m1_rdata,      32'h4444_4444);
        step();
        m1_transfer = 1'b0; PRDATA = 32'h5555_5555;
        step();
        check("tie2_next_grant", 32'(grant), 32'd0);
        check("tie2_next_paddr", PADDR,      32'h300);
        step();
        step();
        check("tie2_m0_ready", 32'(m0_ready), 32'd1);
        check("tie2_m0_rdata", m0_rdata,      32'h5555_5555);
        step();
        m0_transfer = 1'b0; PREADY = 1'b0;

        // ---- completer never answers ----
        m0_addr = 32'h500; m0_transfer = 1'b1;
        step();                                      // SETUP
        step();                                      // ACCESS cycle 1
`ifdef APB_ARB_TIMEOUT_EN
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (m0_ready) begin
                n = i;
                break;
            end
        end
        check("to_cycles",   32'(n),        32'd16);
        check("to_m0_error", 32'(m0_error), 32'd1);
        check("to_m0_rdata", m0_rdata,      32'h0);
        check("to_m1_error", 32'(m1_error), 32'd0);
        step();
        check("to_error_clear", 32'(m0_error), 32'd0);
        m0_transfer = 1'b0;
        step();
        // PREADY in the very cycle the limit is reached completes normally.
        m0_transfer = 1'b1;
        step();                                      // SETUP
        step();                                      // ACCESS cycle 1
        repeat (15) step();                          // ACCESS cycle 16
        check("lim_still_access", 32'(PENABLE),  32'd1);
        check("lim_no_ready",     32'(m0_ready), 32'd0);
        PREADY = 1'b1; PRDATA = 32'h6666_6666;
        step();
        check("lim_m0_ready", 32'(m0_ready), 32'd1);
        check("lim_m0_error", 32'(m0_error), 32'd0);
        check("lim_m0_rdata", m0_rdata,      32'h6666_6666);
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (m0_ready || m1_ready) seen++;
        end
        check("nto_ready_seen", 32'(seen),    32'd0);
        check("nto_penable",    32'(PENABLE), 32'd1);
        PREADY = 1'b1; PRDATA = 32'h6666_6666;
        step();
        check("nto_m0_ready", 32'(m0_ready), 32'd1);
        check("nto_m0_error", 32'(m0_error), 32'd0);
        check("nto_m0_rdata", m0_rdata,      32'h6666_6666);
`endif
        step();
        m0_transfer = 1'b0; PREADY = 1'b0;

        // ---- reset in the middle of ACCESS aborts the transfer ----
        m1_addr = 32'h700; m1_transfer = 1'b1;
        step();                                      // SETUP
        step();                                      // ACCESS
        check("abort_in_access", 32'(PENABLE), 32'd1);
        #2 PRESET = 1'b1;                            // mid-cycle, no edge
        #1;
        check("abort_psel",    32'(PSEL),    32'd0);
        check("abort_penable", 32'(PENABLE), 32'd0);
        check("abort_paddr",   PADDR,        32'h0);
        PREADY = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (m0_ready || m1_ready) seen++;
        end
        PRESET = 1'b0; m1_transfer = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (m0_ready || m1_ready) seen++;
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        check("abort_idle",     32'(PSEL), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the ACCESS-phase cycle limit used only when the timeout feature is compiled in.
REQ-002 SHALL have port PCLK, input, 1 bit: the single clock, rising-edge.
REQ-003 SHALL have port PRESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports m0_transfer and m1_transfer, input, 1 bit each: level requests from requesters 0 and 1.
REQ-005 SHALL have ports m0_addr, m1_addr, m0_wdata and m1_wdata, input, 32 bits each: the per-requester address and write data.
REQ-006 SHALL have ports m0_write and m1_write, input, 1 bit each: 1 means write, 0 means read.
REQ-007 SHALL have ports m0_ready and m1_ready, output, 1 bit each: one-cycle completion pulses.
REQ-008 SHALL have ports m0_rdata and m1_rdata, output, 32 bits each: read data, valid while the matching ready is high.
REQ-009 SHALL have ports m0_error and m1_error, output, 1 bit each: timeout flag, valid while the matching ready is high.
REQ-010 SHALL have port grant, output, 1 bit: the owning requester, valid in SETUP, ACCESS and DONE.
REQ-011 SHALL have ports PADDR and PWDATA, output, 32 bits each: the APB address and write data.
REQ-012 SHALL have ports PWRITE, PSEL and PENABLE, output, 1 bit each: APB control, with PSEL feeding the downstream address decoder.
REQ-013 SHALL have ports PRDATA (input, 32 bits) and PREADY (input, 1 bit): the APB completer response.

Function
REQ-014 SHALL implement the FSM states IDLE, SETUP, ACCESS and DONE.
REQ-015 In IDLE with any transfer high, SHALL select the winner, latch its addr, wdata and write, set grant, and move to SETUP next cycle.
REQ-016 SHALL resolve arbitration round-robin: when both requesters are pending, grant the one not granted last; a single pending requester always wins.
REQ-017 In SETUP, SHALL drive PSEL=1 and PENABLE=0; it SHALL move to ACCESS unconditionally.
REQ-018 In ACCESS, SHALL drive PSEL=1 and PENABLE=1; on PREADY=1 it SHALL capture PRDATA and move to DONE.
REQ-019 In DONE, SHALL pulse only the granted requester's ready for exactly one cycle, present the captured rdata, update last-grant, and return to IDLE.
REQ-020 SHALL hold PADDR, PWDATA and PWRITE stable from SETUP through ACCESS; requester input changes after the latch SHALL be ignored.
REQ-021 SHALL drive PSEL=0 and PENABLE=0 in IDLE and DONE.
REQ-022 Latency SHALL be: request in IDLE cycle N, SETUP at N+1, ACCESS at N+2, and ready at N+3 when PREADY is high in the first ACCESS cycle.
REQ-023 A requester SHALL deassert transfer in the cycle after its ready; the arbiter SHALL NOT re-grant a requester during its own DONE cycle.
REQ-024 A non-granted requester with transfer held high SHALL be granted at the next IDLE, with no starvation.
REQ-025 On a write transfer, rdata SHALL be 0.
REQ-026 rdata SHALL hold its value outside DONE.

Reset
REQ-027 On PRESET=1, the block SHALL immediately, without waiting for a clock, go to IDLE and drive PSEL=0, PENABLE=0, both ready=0 and both error=0.
REQ-028 Reset SHALL clear PADDR, PWDATA, PWRITE, both rdata and grant to 0, and set last-grant to 1 so requester 0 wins the first tie.
REQ-029 Reset during SETUP or ACCESS SHALL abort the transfer with no ready pulse.

Configuration
REQ-030 With APB_ARB_TIMEOUT_EN defined, an ACCESS-cycle counter SHALL start at 0 on entry to ACCESS.
REQ-031 With APB_ARB_TIMEOUT_EN defined, after TIMEOUT_CYCLES ACCESS cycles without PREADY the FSM SHALL move to DONE with rdata=0 and the granted requester's error=1.
REQ-032 With APB_ARB_TIMEOUT_EN defined, PREADY arriving in the same cycle the limit is reached SHALL take priority and complete normally with error=0.
REQ-033 Without APB_ARB_TIMEOUT_EN, ACCESS SHALL wait indefinitely for PREADY, both error outputs SHALL be tied to 0, and no counter SHALL be synthesized.

Verification
REQ-034 Single read: m0 reads 0x1000_0004 with PRDATA=0xA5A5_0001 and PREADY=1 on the first ACCESS cycle -> m0_ready at N+3, m0_rdata=0xA5A5_0001, m1_ready stays 0.
REQ-035 Wait states: m1 writes 0xDEAD_BEEF to 0x1000_2000 with PREADY low for 3 ACCESS cycles -> PADDR and PWDATA stable for all 4 ACCESS cycles, and m1_ready one cycle after PREADY.
REQ-036 Contention: both requesters assert in the same cycle after reset -> m0 served first, then m1; both assert again -> m1 served first.
REQ-037 Reset mid-ACCESS: assert PRESET during ACCESS -> PSEL and PENABLE go to 0 the same cycle, with no ready pulse.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=16): PREADY held at 0 -> m0_ready with m0_error=1 and m0_rdata=0 after 16 ACCESS cycles; with the macro off, no ready is seen after 100 cycles.
